// File: rtl/pipe_result_collector.sv
// -----------------------------------------------------------------------------
// pipe_result_collector
//
// Purpose:
//   Receiving end of a fixed-latency, non-stallable element pipeline. Hands out
//   credits to the issuing logic so that every in-flight result is guaranteed
//   a FIFO slot, buffers the results, and presents them first-word-fall-through
//   to a back-pressured downstream consumer (valid/ready).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   issue_req    upstream wants to launch one operation this cycle
//   issue_grant  combinational grant: issue_req AND (credits != 0)
//   in_valid     pipeline result valid (cannot be back-pressured)
//   in_data      pipeline result
//   out_valid    FIFO head valid
//   out_data     FIFO head element (don't-care while out_valid = 0)
//   out_ready    downstream accepts the head this cycle
//   credits      free credits, 0..DEPTH
//   fill         entries currently stored, 0..DEPTH
//   overflow     sticky: a result arrived while full with no pop (data lost)
// -----------------------------------------------------------------------------
module pipe_result_collector #(
   parameter int element_width = 64,
   parameter int DEPTH         = 8,
   parameter int ADDR_W        = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_req,
   output logic                     issue_grant,
   input  logic                     in_valid,
   input  logic [element_width-1:0] in_data,
   output logic                     out_valid,
   output logic [element_width-1:0] out_data,
   input  logic                     out_ready,
   output logic [ADDR_W:0]          credits,
   output logic [ADDR_W:0]          fill,
   output logic                     overflow
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   // Pointer wrap relies on natural ADDR_W-bit rollover.
   if (DEPTH != (1 << ADDR_W) || DEPTH < 2) begin : g_bad_depth
      $error("pipe_result_collector: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
   end

   // Storage: written synchronously, read combinationally for fall-through.
   logic [element_width-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   logic [ADDR_W:0]   credits_q, credits_d;
   logic              overflow_q, overflow_d;

   logic full;
   logic pop;
   logic push_accept;
   logic push_drop;

   assign full        = (fill_q == FULL_CNT);
   assign out_valid   = (fill_q != '0);
   assign out_data    = mem[rd_ptr_q];
   assign pop         = out_valid & out_ready;
   assign issue_grant = issue_req & (credits_q != '0);

   // A full FIFO can still take a result in the cycle its head is popped,
   // because the freed slot and the new slot are the same cycle's traffic.
   assign push_accept = in_valid & (~full | pop);
   assign push_drop   = in_valid & full & ~pop;

   assign credits  = credits_q;
   assign fill     = fill_q;
   assign overflow = overflow_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      credits_d  = credits_q;
      overflow_d = overflow_q;

      if (push_accept) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      case ({push_accept, pop})
         2'b10:   fill_d = fill_q + (ADDR_W+1)'(1);
         2'b01:   fill_d = fill_q - (ADDR_W+1)'(1);
         default: fill_d = fill_q;
      endcase

      // A credit leaves with each grant and returns with each pop. A pop at
      // full credit is an upstream protocol error; saturate rather than wrap.
      case ({issue_grant, pop})
         2'b10:   credits_d = credits_q - (ADDR_W+1)'(1);
         2'b01:   credits_d = (credits_q == FULL_CNT) ? credits_q
                                                      : credits_q + (ADDR_W+1)'(1);
         default: credits_d = credits_q;
      endcase

      if (push_drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         credits_q  <= FULL_CNT;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         credits_q  <= credits_d;
         overflow_q <= overflow_d;
      end
   end

   // Memory contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_accept) begin
         mem[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_result_collector.sv
// -----------------------------------------------------------------------------
// tb_pipe_result_collector
//
// Self-checking bench for pipe_result_collector. A queue-based reference model
// tracks FIFO contents, credits and overflow; a compare process checks every
// output on each falling edge. Directed phases pin the model with literal
// expectations, then a randomized phase drives an emulated fixed-latency
// pipeline with occasional illegal extra results.
// -----------------------------------------------------------------------------
module tb_pipe_result_collector;

   localparam int W     = 64;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int LAT   = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          issue_req = 1'b0;
   logic          issue_grant;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready = 1'b0;
   logic [AW:0]   credits;
   logic [AW:0]   fill;
   logic          overflow;

   pipe_result_collector #(
      .element_width (W),
      .DEPTH         (DEPTH),
      .ADDR_W        (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_req   (issue_req),
      .issue_grant (issue_grant),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .credits     (credits),
      .fill        (fill),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] mq[$];
   int           m_credits = DEPTH;
   bit           m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_credits = DEPTH;
         m_ovf     = 1'b0;
      end else begin
         bit was_full, pop, grant;
         was_full = (mq.size() == DEPTH);
         pop      = (mq.size() != 0) && out_ready;
         grant    = issue_req && (m_credits != 0);
         if (grant && !pop) m_credits = m_credits - 1;
         else if (pop && !grant && m_credits < DEPTH) m_credits = m_credits + 1;
         if (pop) void'(mq.pop_front());
         if (in_valid) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else mq.push_back(in_data);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", W'(out_valid), W'(mq.size() != 0));
         chk("fill", W'(fill), W'(mq.size()));
         chk("credits", W'(credits), W'(m_credits));
         chk("overflow", W'(overflow), W'(m_ovf));
         chk("issue_grant", W'(issue_grant), W'(issue_req && (m_credits != 0)));
         if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      end
   end

   // ---------------- emulated upstream pipeline ----------------
   bit           pv[LAT];
   logic [W-1:0] pd[LAT];
   logic [W-1:0] seq;

   // One clock of stimulus. Results come from the pipeline tail unless a
   // forced (possibly illegal) result is requested.
   task automatic cycle(input bit req, input bit rdy, input bit fv, input logic [W-1:0] fd);
      bit g;
      issue_req = req;
      out_ready = rdy;
      if (fv) begin
         in_valid = 1'b1;
         in_data  = fd;
      end else begin
         in_valid = pv[LAT-1];
         in_data  = pd[LAT-1];
      end
      g = req && (m_credits != 0);
      @(posedge clk);
      #1;
      for (int i = LAT-1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = g;
      if (g) seq = seq + 1;
      pd[0] = seq;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      issue_req = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      for (int i = 0; i < LAT; i++) begin
         pv[i] = 1'b0;
         pd[i] = '0;
      end
      seq = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      chk_en = 1'b1;

      // Reset state and a single issue.
      chk("rst_credits", W'(credits), W'(8));
      chk("rst_fill", W'(fill), W'(0));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_overflow", W'(overflow), W'(0));
      cycle(1, 0, 0, '0);
      chk("one_issue_credits", W'(credits), W'(7));

      // Eight issues exhaust credits; the ninth is refused.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
      chk("exhaust_credits", W'(credits), W'(0));
      cycle(1, 0, 0, '0);
      chk("ninth_credits", W'(credits), W'(0));
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0);
      chk("full_fill", W'(fill), W'(8));
      chk("full_overflow", W'(overflow), W'(0));
      chk("full_head", out_data, W'(1));

      // Drain in order.
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", out_data, W'(i + 1));
         cycle(0, 1, 0, '0);
      end
      chk("drain_credits", W'(credits), W'(8));
      chk("drain_out_valid", W'(out_valid), W'(0));

      // Full FIFO: push with pop accepted, push without pop dropped.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, W'(16 + i));
      chk("ovf_fill_pre", W'(fill), W'(8));
      cycle(0, 1, 1, W'(8'hAA));
      chk("ovf_fill_pop", W'(fill), W'(8));
      chk("ovf_flag_pop", W'(overflow), W'(0));
      chk("ovf_head_pop", out_data, W'(17));
      cycle(0, 0, 1, W'(8'hAA));
      chk("ovf_flag_drop", W'(overflow), W'(1));
      chk("ovf_fill_drop", W'(fill), W'(8));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0);
      chk("ovf_sticky", W'(overflow), W'(1));
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);
      chk("ovf_drained", W'(out_valid), W'(0));
      chk("ovf_sticky2", W'(overflow), W'(1));

      // Grant and pop together at credits=3.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, '0);
      chk("c3_credits_pre", W'(credits), W'(3));
      chk("c3_fill_pre", W'(fill), W'(5));
      cycle(1, 1, 0, '0);
      chk("c3_credits_post", W'(credits), W'(3));
      chk("c3_fill_post", W'(fill), W'(4));

      // Pointer wrap at fill=1.
      do_reset();
      cycle(0, 0, 1, W'(256));
      for (int i = 1; i <= 20; i++) cycle(0, 1, 1, W'(256 + i));
      chk("wrap_fill", W'(fill), W'(1));
      chk("wrap_head", out_data, W'(276));
      chk("wrap_credits", W'(credits), W'(8));

      // Asynchronous reset mid-operation at fill=5, credits=1.
      do_reset();
      for (int i = 0; i < 7; i++) cycle(1, 0, 0, '0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
      chk("mid_fill_pre", W'(fill), W'(5));
      chk("mid_credits_pre", W'(credits), W'(1));
      rst = 1'b1;
      #1;
      chk("mid_fill", W'(fill), W'(0));
      chk("mid_credits", W'(credits), W'(8));
      chk("mid_out_valid", W'(out_valid), W'(0));
      chk("mid_overflow", W'(overflow), W'(0));
      do_reset();

      // Randomized traffic with occasional illegal extra results.
      for (int n = 0; n < 3000; n++) begin
         bit req, rdy, fv;
         req = ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 3) != 0);
         if (n % 500 < 150) rdy = ($urandom_range(0, 7) == 0);
         fv  = ($urandom_range(0, 15) == 0) && !pv[LAT-1];
         cycle(req, rdy, fv, {$urandom, $urandom});
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
